row_reduce_scanner: RTL
=======================

Name: row_reduce_scanner

Overview:
- Parametrised, sequential successor to the fixed-width bubbled gate primitives.
- Scans ROWS words of WIDTH bits from a synchronous-read board memory, one row per cycle.
- Applies a per-bit bubble (inversion) mask and a selectable reduction (AND/OR/XOR/NOR) to each row.
- Reports which rows hit, the hit count and the first hit; the tetris core uses it for full-row (line-clear) detection.

Parameters:
- WIDTH, 12, bits per row (cells per board line).
- ROWS, 20, rows scanned per pass.
- BubblesMask, 0, WIDTH-bit mask; bit i=1 inverts RowData[i] before reduction.
- AW, clog2(ROWS) = 5, address and index width.
- CW, clog2(ROWS+1) = 5, count width.

Ports:
- Clock  in  1  system clock; all state changes on the rising edge.
- Reset  in  1  asynchronous, active-high reset.
- Start  in  1  request a scan pass; sampled at a rising edge.
- Mode  in  2  reduction select, latched when Start is accepted: 00 AND, 01 OR, 10 XOR, 11 NOR.
- RowAddr  out  AW  board memory read address.
- RowRead  out  1  read strobe for RowAddr.
- RowData  in  WIDTH  memory data; valid the cycle after RowRead/RowAddr.
- Busy  out  1  scan in progress.
- Done  out  1  one-cycle pulse; results valid.
- HitMask  out  ROWS  bit r=1 when row r reduced to 1.
- HitCount  out  CW  popcount of HitMask.
- AnyHit  out  1  HitCount != 0.
- FirstHit  out  AW  lowest r with HitMask[r]=1; 0 when AnyHit=0.

Behaviour:
- Reset (async): state IDLE; RowAddr=0, RowRead=0, Busy=0, Done=0, HitMask=0, HitCount=0, AnyHit=0, FirstHit=0, latched mode=AND.
- States: IDLE, SCAN, DONE.
- IDLE/DONE, Start=1 at edge E0:
  - go to SCAN; latch Mode.
  - clear HitMask, HitCount, FirstHit and AnyHit.
  - RowAddr=0, RowRead=1, Busy=1.
- SCAN, each edge:
  - capture the reduction of RowData into HitMask[RowAddr_prev], where RowAddr_prev is the address issued the previous cycle. No capture at the first SCAN edge.
  - increment RowAddr while RowAddr < ROWS-1.
  - once RowAddr=ROWS-1 has been issued, the next edge captures row ROWS-1 and moves to DONE: RowRead=0, Busy=0, Done=1.
- Timing: Done is high in the cycle following edge E0+ROWS+1; 21 edges after acceptance for the defaults. Throughput is 1 row/cycle with no stalls.
- DONE lasts exactly one cycle, then IDLE; Start sampled in DONE restarts immediately, as from IDLE.
- Results (HitMask, HitCount, AnyHit, FirstHit) hold from Done until the next accepted Start or Reset.
- HitCount, AnyHit and FirstHit are updated incrementally per captured row:
  - count saturates at ROWS and cannot overflow.
  - FirstHit is written only on the first hit of the pass.
- Reduction: real = RowData XOR BubblesMask; AND = &real, OR = |real, XOR = ^real, NOR = ~|real.
- Start while Busy=1 is ignored; the Mode change is ignored too.
- Mode changes outside Start acceptance have no effect.
- Reset mid-scan aborts immediately to the reset values; no Done is produced.
- RowAddr never exceeds ROWS-1; no wrap-around.
- RowAddr is held at its last value when RowRead=0.
- ROWS=1 is legal: Done at E0+2.

Decomposition:
- Shared package:
  - Mode encodings MODE_AND=2'b00, MODE_OR=2'b01, MODE_XOR=2'b10, MODE_NOR=2'b11.
  - State encodings IDLE/SCAN/DONE.
  - Width helper for clog2.
- One combinational sub-module, gate_reduce_masked (parameters WIDTH, BubblesMask; inputs data, mode; output bit), instanced once. It is reusable as the generalised N-input bubbled gate.

Test Plan:
- Defaults, BubblesMask=0, Mode=AND; rows 3 and 19 = 0xFFF, all others 0x7FF.
  - Done exactly 21 edges after Start; HitMask=0x80008, HitCount=2, AnyHit=1, FirstHit=3.
  - RowAddr sequence 0..19, one per cycle.
- BubblesMask=0x001, Mode=AND; row 5 = 0xFFE, row 6 = 0xFFF.
  - HitMask=0x00020, HitCount=1, FirstHit=5.
- Mode=OR, all rows 0x000.
  - HitMask=0, HitCount=0, AnyHit=0, FirstHit=0.
  - Then Mode=XOR, row 0 = 0x001, others 0x003: HitMask=0x00001.
- Start pulsed again at cycle 5 of a pass with Mode changed to NOR.
  - Ignored: single Done at edge 21; results match the original AND mode.
  - Start in the Done cycle restarts; second Done 21 edges later.
- Reset asserted asynchronously mid-SCAN (RowAddr=9).
  - All outputs go to reset values without a clock edge; no Done.
  - A subsequent Start gives a correct full pass.
- Mode=NOR, all rows 0x000.
  - HitMask=0xFFFFF, HitCount=20 (saturation bound), FirstHit=0, AnyHit=1.

Source files
------------

// File: rtl/row_reduce_scanner_pkg.sv
// Shared encodings and width helper for the row reduction scanner and its gate.
package row_reduce_scanner_pkg;

    typedef enum logic [1:0] {
        MODE_AND = 2'b00,
        MODE_OR  = 2'b01,
        MODE_XOR = 2'b10,
        MODE_NOR = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StScan = 2'b01,
        StDone = 2'b10
    } state_e;

    // clog2 that never yields a zero-width vector (ROWS=1 still needs one address bit)
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/row_reduce_scanner_gate.sv
// Generalised N-input bubbled gate: per-bit inversion mask followed by a selectable reduction.
module gate_reduce_masked
    import row_reduce_scanner_pkg::*;
#(
    parameter int unsigned      WIDTH       = 12,
    parameter logic [WIDTH-1:0] BubblesMask = '0
) (
    input  logic [WIDTH-1:0] data,
    input  mode_e            mode,
    output logic             hit
);

    logic [WIDTH-1:0] real_bits;

    always_comb begin
        real_bits = data ^ BubblesMask;
        hit       = 1'b0;
        unique case (mode)
            MODE_AND: hit = &real_bits;
            MODE_OR:  hit = |real_bits;
            MODE_XOR: hit = ^real_bits;
            MODE_NOR: hit = ~|real_bits;
        endcase
    end

endmodule

// File: rtl/row_reduce_scanner.sv
// Streams ROWS board lines from a synchronous-read memory, reduces each one and
// accumulates a hit mask, hit count and first hit index (line-clear detection).
module row_reduce_scanner
    import row_reduce_scanner_pkg::*;
#(
    parameter int unsigned      WIDTH       = 12,
    parameter int unsigned      ROWS        = 20,
    parameter logic [WIDTH-1:0] BubblesMask = '0,
    parameter int unsigned      AW          = clog2_min1(ROWS),
    parameter int unsigned      CW          = clog2_min1(ROWS + 1)
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Start,
    input  logic [1:0]       Mode,
    output logic [AW-1:0]    RowAddr,
    output logic             RowRead,
    input  logic [WIDTH-1:0] RowData,
    output logic             Busy,
    output logic             Done,
    output logic [ROWS-1:0]  HitMask,
    output logic [CW-1:0]    HitCount,
    output logic             AnyHit,
    output logic [AW-1:0]    FirstHit
);

    localparam logic [AW-1:0] LastRow  = AW'(ROWS - 1);
    localparam logic [CW-1:0] MaxCount = CW'(ROWS);

    state_e          state_q;
    mode_e           mode_q;
    logic [AW-1:0]   addr_q;
    logic            read_q;
    logic            busy_q;
    logic            done_q;
    logic [ROWS-1:0] hit_mask_q;
    logic [CW-1:0]   count_q;
    logic            any_q;
    logic [AW-1:0]   first_q;
    // Address issued in the previous cycle; its data is on RowData now.
    logic            cap_valid_q;
    logic [AW-1:0]   cap_addr_q;
    logic            row_hit;

    gate_reduce_masked #(
        .WIDTH       (WIDTH),
        .BubblesMask (BubblesMask)
    ) u_gate (
        .data (RowData),
        .mode (mode_q),
        .hit  (row_hit)
    );

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q     <= StIdle;
            mode_q      <= MODE_AND;
            addr_q      <= '0;
            read_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            hit_mask_q  <= '0;
            count_q     <= '0;
            any_q       <= 1'b0;
            first_q     <= '0;
            cap_valid_q <= 1'b0;
            cap_addr_q  <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle, StDone: begin
                    state_q <= StIdle;
                    if (Start) begin
                        state_q     <= StScan;
                        mode_q      <= mode_e'(Mode);
                        hit_mask_q  <= '0;
                        count_q     <= '0;
                        any_q       <= 1'b0;
                        first_q     <= '0;
                        addr_q      <= '0;
                        read_q      <= 1'b1;
                        busy_q      <= 1'b1;
                        cap_valid_q <= 1'b0;
                    end
                end
                StScan: begin
                    cap_valid_q <= read_q;
                    cap_addr_q  <= addr_q;
                    if (addr_q < LastRow) begin
                        addr_q <= addr_q + AW'(1);
                    end
                    if (cap_valid_q) begin
                        if (row_hit) begin
                            hit_mask_q[cap_addr_q] <= 1'b1;
                            if (count_q < MaxCount) begin
                                count_q <= count_q + CW'(1);
                            end
                            if (!any_q) begin
                                first_q <= cap_addr_q;
                            end
                            any_q <= 1'b1;
                        end
                        if (cap_addr_q == LastRow) begin
                            state_q     <= StDone;
                            read_q      <= 1'b0;
                            busy_q      <= 1'b0;
                            done_q      <= 1'b1;
                            cap_valid_q <= 1'b0;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign RowAddr  = addr_q;
    assign RowRead  = read_q;
    assign Busy     = busy_q;
    assign Done     = done_q;
    assign HitMask  = hit_mask_q;
    assign HitCount = count_q;
    assign AnyHit   = any_q;
    assign FirstHit = first_q;

endmodule
